// File: rtl/load_store_unit.sv
// Data-side bus interface: turns core load/store requests into valid/ready bus cycles,
// stalls the core while the bus is busy, and returns aligned, extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_fault,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic        fault_q;

    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] load_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        handshake;
    logic        timeout;

    assign handshake = mem_valid & mem_ready;
    assign timeout   = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign cpu_fault = fault_q;

    // Loads allow the unsigned variants; stores only B/H/W.
    always_comb begin
        legal = 1'b0;
        case (cpu_funct3)
            3'b000:  legal = 1'b1;
            3'b100:  legal = !cpu_we;
            3'b001:  legal = !cpu_addr[0];
            3'b101:  legal = !cpu_we && !cpu_addr[0];
            3'b010:  legal = (cpu_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be        = 4'b1111;
        wdata_rep = cpu_wdata;
        case (cpu_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << cpu_addr[1:0];
                wdata_rep = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << cpu_addr[1:0];
                wdata_rep = {2{cpu_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = cpu_wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cpu_stall = 1'b0;
        case (state_q)
            StIdle: begin
                cpu_stall = cpu_req;
                if (cpu_req) state_d = legal ? StBus : StDone;
            end
            StBus: begin
                cpu_stall = 1'b1;
                if (handshake || timeout) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (reset) cpu_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'h0;
            funct3_q  <= 3'b000;
            lane_q    <= 2'b00;
            fault_q   <= 1'b0;
            cpu_rdata <= 32'h0;
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        if (legal) begin
                            mem_valid <= 1'b1;
                            mem_addr  <= {cpu_addr[31:2], 2'b00};
                            mem_we    <= cpu_we;
                            mem_be    <= be;
                            mem_wdata <= wdata_rep;
                            funct3_q  <= cpu_funct3;
                            lane_q    <= cpu_addr[1:0];
                            cnt_q     <= 8'h0;
                            fault_q   <= 1'b0;
                        end else begin
                            fault_q   <= 1'b1;
                            cpu_rdata <= 32'h0;
                        end
                    end
                end
                StBus: begin
                    // A ready on the final timeout cycle still completes cleanly.
                    if (handshake) begin
                        mem_valid <= 1'b0;
                        cpu_rdata <= mem_we ? 32'h0 : load_ext;
                        fault_q   <= 1'b0;
                    end else if (timeout) begin
                        mem_valid <= 1'b0;
                        cpu_rdata <= 32'h0;
                        fault_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone:  fault_q <= 1'b0;
                default: fault_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized accesses against a
// behavioural model, and a reset-during-bus sequence.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_fault;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_funct3 (cpu_funct3),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .cpu_fault  (cpu_fault),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          waits;
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        fault;
        int          bus;
    } vec_t;

    task automatic chk(input string name, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", name, what, act, exp);
        end
    endtask

    // Reference: expected outcome derived from size/alignment arithmetic.
    function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] word,
                                   input int waits);
        vec_t v;
        int nb;
        int lane;
        logic lgl;
        logic [31:0] mask;
        logic [31:0] val;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.word = word; v.waits = waits;
        nb   = 1 << f3[1:0];
        lane = int'(addr % 4);
        lgl  = ((f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5))) && (addr % nb == 0);
        v.be = (nb >= 4) ? 4'hF : 4'(((1 << nb) - 1) << lane);
        for (int i = 0; i < 4; i++) v.exp_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
        mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        val  = (word >> (8 * lane)) & mask;
        if (f3 < 3'd4 && nb < 4 && val[8*nb-1]) val = val | ~mask;
        if (!lgl) begin
            v.fault = 1'b1; v.bus = 0; v.exp_rd = 32'h0;
        end else if (waits + 1 > TO) begin
            v.fault = 1'b1; v.bus = TO; v.exp_rd = 32'h0;
        end else begin
            v.fault = 1'b0; v.bus = waits + 1; v.exp_rd = we ? 32'h0 : val;
        end
        return v;
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        int          stalls = 0;
        int          bus = 0;
        logic        done = 1'b0;
        logic        stable = 1'b1;
        logic        fault = 1'b0;
        logic        got_we = 1'b0;
        logic [31:0] a = '0;
        logic [31:0] wd = '0;
        logic [31:0] rd = '0;
        logic [3:0]  be = '0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_funct3 = v.f3; cpu_addr = v.addr;
        cpu_wdata = v.wdata; mem_rdata = v.word; mem_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (mem_valid) begin
                if (bus == 0) begin
                    a = mem_addr; be = mem_be; got_we = mem_we; wd = mem_wdata;
                end else if (mem_addr !== a || mem_be !== be || mem_we !== got_we ||
                             mem_wdata !== wd) begin
                    stable = 1'b0;
                end
                bus++;
                mem_ready = (bus > v.waits);
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (cpu_stall) stalls++;
            else begin
                done = 1'b1; fault = cpu_fault; rd = cpu_rdata; cpu_req = 1'b0;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        cpu_req   = 1'b0;
        chk(name, "done", 32'(done), 32'd1);
        chk(name, "stall_cycles", stalls, 1 + v.bus);
        chk(name, "bus_cycles", bus, v.bus);
        chk(name, "fault", 32'(fault), 32'(v.fault));
        chk(name, "fault_cleared", 32'(cpu_fault), 32'd0);
        if (v.bus > 0) begin
            chk(name, "mem_addr", a, {v.addr[31:2], 2'b00});
            chk(name, "mem_we", 32'(got_we), 32'(v.we));
            chk(name, "mem_be", 32'(be), 32'(v.be));
            chk(name, "stable", 32'(stable), 32'd1);
            if (v.we) chk(name, "mem_wdata", wd, v.exp_wd);
        end
        if (!(v.fault && v.bus > 0)) chk(name, "rdata", rd, v.exp_rd);
    endtask

    vec_t tbl[14];
    vec_t rv;

    initial begin
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;

        tbl[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 2, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 3};
        tbl[1]  = '{1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 4'h8, 32'hA5A5A5A5, 32'h0, 1'b0, 1};
        tbl[2]  = '{1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 1, 4'hC, 32'h12341234, 32'h0, 1'b0, 2};
        tbl[3]  = '{1'b0, 3'd0, 32'h102, 32'h0, 32'h12F03456, 0, 4'h4, 32'h0, 32'hFFFFFFF0, 1'b0, 1};
        tbl[4]  = '{1'b0, 3'd4, 32'h102, 32'h0, 32'h12F03456, 0, 4'h4, 32'h0, 32'h000000F0, 1'b0, 1};
        tbl[5]  = '{1'b0, 3'd1, 32'h102, 32'h0, 32'h12F03456, 1, 4'hC, 32'h0, 32'h000012F0, 1'b0, 2};
        tbl[6]  = '{1'b0, 3'd2, 32'h100, 32'h0, 32'h12F03456, 0, 4'hF, 32'h0, 32'h12F03456, 1'b0, 1};
        tbl[7]  = '{1'b0, 3'd5, 32'h100, 32'h0, 32'h00008001, 0, 4'h3, 32'h0, 32'h00008001, 1'b0, 1};
        tbl[8]  = '{1'b0, 3'd1, 32'h100, 32'h0, 32'h00008001, 0, 4'h3, 32'h0, 32'hFFFF8001, 1'b0, 1};
        tbl[9]  = '{1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1'b1, 0};
        tbl[10] = '{1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1'b1, 0};
        tbl[11] = '{1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1'b1, 0};
        tbl[12] = '{1'b1, 3'd2, 32'h200, 32'h11, 32'h0, 100, 4'hF, 32'h11, 32'h0, 1'b1, TO};
        tbl[13] = '{1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 3, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, TO};

        // Reset state, with cpu_req held high to show stall is masked.
        repeat (2) @(negedge clk);
        #1;
        chk("reset", "stall", 32'(cpu_stall), 32'd0);
        chk("reset", "mem_valid", 32'(mem_valid), 32'd0);
        chk("reset", "mem_be", 32'(mem_be), 32'd0);
        chk("reset", "cpu_rdata", cpu_rdata, 32'd0);
        chk("reset", "cpu_fault", 32'(cpu_fault), 32'd0);
        cpu_req = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset while the bus is waiting abandons the transaction.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'd2; cpu_addr = 32'h300;
        @(negedge clk);
        chk("rst_bus", "in_bus", 32'(mem_valid), 32'd1);
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_bus", "mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_bus", "stall", 32'(cpu_stall), 32'd0);
        chk("rst_bus", "fault", 32'(cpu_fault), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_bus", "idle_valid", 32'(mem_valid), 32'd0);
        chk("rst_bus", "idle_fault", 32'(cpu_fault), 32'd0);
        run_vec("after_rst0", tbl[0]);
        run_vec("after_rst1", tbl[3]);

        for (int i = 0; i < 150; i++) begin
            rv = model(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 5)));
            run_vec($sformatf("rand%0d", i), rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
